// File: rtl/_riscv_defines.sv
// Shared constants for the RISC-V core and its memory-side blocks.
//   ADDR_WIDTH        : byte address width of the instruction bus
//   AXI_RESP_*        : AXI read response codes
//   ICACHE_LINE_WORDS : 32-bit words per instruction cache line
package _riscv_defines;
  localparam int         ADDR_WIDTH        = 32;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY   = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR   = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR   = 2'b11;
  localparam int         ICACHE_LINE_WORDS = 4;
endpackage

// File: rtl/axi_read_if.sv
// AXI read-only channel bundle (AR + R) between one master and one slave.
//   master : drives araddr/arvalid/arlen/rready, samples arready/rdata/rvalid/rlast/rresp
//   slave  : the mirror image
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the source holds its payload and valid until that edge.
interface axi_read_if;
  import _riscv_defines::*;

  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic [7:0]            arlen;
  logic                  arready;
  logic [31:0]           rdata;
  logic                  rvalid;
  logic                  rlast;
  logic [1:0]            rresp;
  logic                  rready;

  modport master (
    output araddr, arvalid, arlen, rready,
    input  arready, rdata, rvalid, rlast, rresp
  );

  modport slave (
    input  araddr, arvalid, arlen, rready,
    output arready, rdata, rvalid, rlast, rresp
  );
endinterface

// File: rtl/icache_line_ram.sv
// Tag and data storage for the instruction cache.
//   clk          : write clock
//   we           : write a full line (tag + all words) at widx
//   widx/wtag    : line index and tag to write
//   wline        : line data to write
//   ridx         : line index to read (combinational read)
//   rtag/rline   : stored tag and data at ridx
// Contents are not reset; the valid bits that qualify them live in the top.
module icache_line_ram #(
  parameter int LINE_NUM   = 16,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 24,
  parameter int IDX_W      = 4
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [IDX_W-1:0]             widx,
  input  logic [TAG_W-1:0]             wtag,
  input  logic [LINE_WORDS-1:0][31:0]  wline,
  input  logic [IDX_W-1:0]             ridx,
  output logic [TAG_W-1:0]             rtag,
  output logic [LINE_WORDS-1:0][31:0]  rline
);

  logic [TAG_W-1:0]            tag_mem  [LINE_NUM];
  logic [LINE_WORDS-1:0][31:0] data_mem [LINE_NUM];

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[widx]  <= wtag;
      data_mem[widx] <= wline;
    end
  end

  assign rtag  = tag_mem[ridx];
  assign rline = data_mem[ridx];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with an AXI line-refill master.
//   clk, rst_n      : clock, synchronous active-low reset
//   cpu_req_valid   : fetch request; accepted when cpu_req_ready is also high
//   cpu_req_ready   : high only in IDLE and not during a flush pulse
//   cpu_addr        : fetch byte address, bits [1:0] ignored
//   flush           : one-cycle pulse invalidating every line
//   cpu_resp_valid  : one-cycle response pulse (no backpressure)
//   cpu_rdata       : fetched word, valid with cpu_resp_valid
//   cpu_resp_err    : refill saw a non-OKAY rresp on some beat
//   axi_if          : AXI read master port toward instruction memory
// Handshakes: cpu request and every AXI channel transfer on a rising edge
// where valid and ready are both high; the response side has no ready.
module icache
  import _riscv_defines::*;
#(
  parameter int LINE_NUM   = 16,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  flush,
  output logic                  cpu_resp_valid,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_resp_err,
  axi_read_if.master            axi_if
);

  localparam int         WOFF_W = $clog2(LINE_WORDS);
  localparam int         IDX_W  = $clog2(LINE_NUM);
  localparam int         TAG_W  = ADDR_WIDTH - 2 - WOFF_W - IDX_W;
  localparam logic [7:0] ARLEN  = 8'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, AR, R, FILL} state_t;

  state_t state_q, state_d;

  // Latched word address of the request in flight (byte offset dropped).
  logic [ADDR_WIDTH-3:0]       waddr_q;
  logic [WOFF_W-1:0]           woff;
  logic [IDX_W-1:0]            idx;
  logic [TAG_W-1:0]            tag;

  logic [LINE_NUM-1:0]         valid_q;
  logic                        flush_pend_q;
  logic                        err_q;
  logic [WOFF_W-1:0]           beat_q;
  logic [LINE_WORDS-1:0][31:0] line_buf;

  logic [TAG_W-1:0]            rd_tag;
  logic [LINE_WORDS-1:0][31:0] rd_line;
  logic                        hit;
  logic                        r_fire;
  logic                        unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];

  assign woff   = waddr_q[WOFF_W-1:0];
  assign idx    = waddr_q[WOFF_W +: IDX_W];
  assign tag    = waddr_q[ADDR_WIDTH-3 -: TAG_W];
  assign hit    = valid_q[idx] && (rd_tag == tag);
  assign r_fire = axi_if.rvalid && axi_if.rready;

  icache_line_ram #(
    .LINE_NUM   (LINE_NUM),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W),
    .IDX_W      (IDX_W)
  ) u_line_ram (
    .clk   (clk),
    .we    (state_q == FILL),
    .widx  (idx),
    .wtag  (tag),
    .wline (line_buf),
    .ridx  (idx),
    .rtag  (rd_tag),
    .rline (rd_line)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    cpu_req_ready  = 1'b0;
    axi_if.arvalid = 1'b0;
    axi_if.rready  = 1'b0;
    case (state_q)
      IDLE: begin
        cpu_req_ready = !flush;
        if (cpu_req_valid && !flush) state_d = LOOKUP;
      end
      LOOKUP: state_d = hit ? IDLE : AR;
      AR: begin
        axi_if.arvalid = 1'b1;
        if (axi_if.arready) state_d = R;
      end
      R: begin
        axi_if.rready = 1'b1;
        // rlast ends the burst whatever the beat counter says.
        if (axi_if.rvalid && axi_if.rlast) state_d = FILL;
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request address and refill buffer carry no reset value.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && cpu_req_valid && !flush) waddr_q <= cpu_addr[ADDR_WIDTH-1:2];
    if (state_q == R && r_fire) line_buf[beat_q] <= axi_if.rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q        <= '0;
      flush_pend_q   <= 1'b0;
      err_q          <= 1'b0;
      beat_q         <= '0;
      cpu_resp_valid <= 1'b0;
      cpu_resp_err   <= 1'b0;
      cpu_rdata      <= '0;
      axi_if.araddr  <= '0;
      axi_if.arlen   <= '0;
    end else begin
      cpu_resp_valid <= 1'b0;
      cpu_resp_err   <= 1'b0;
      case (state_q)
        LOOKUP: begin
          if (hit) begin
            cpu_resp_valid <= 1'b1;
            cpu_rdata      <= rd_line[woff];
          end else begin
            // Held unchanged until the next miss, so stable through the burst.
            axi_if.araddr <= {waddr_q[ADDR_WIDTH-3:WOFF_W], {(WOFF_W+2){1'b0}}};
            axi_if.arlen  <= ARLEN;
          end
        end
        AR: if (axi_if.arready) beat_q <= '0;
        R: begin
          if (r_fire) begin
            beat_q <= beat_q + WOFF_W'(1);
            err_q  <= err_q | (axi_if.rresp != AXI_RESP_OKAY);
          end
        end
        FILL: begin
          valid_q[idx]   <= !err_q;
          cpu_resp_valid <= 1'b1;
          cpu_rdata      <= line_buf[woff];
          cpu_resp_err   <= err_q;
          err_q          <= 1'b0;
        end
        default: ;
      endcase

      // Flush: immediate in IDLE; otherwise deferred to the edge that returns
      // to IDLE, where it overrides the valid bit set by FILL above.
      if (state_q == IDLE) begin
        if (flush) valid_q <= '0;
      end else if (state_d == IDLE) begin
        if (flush || flush_pend_q) valid_q <= '0;
        flush_pend_q <= 1'b0;
      end else if (flush) begin
        flush_pend_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
module tb_icache;
  import _riscv_defines::*;

  localparam int LN = 16;
  localparam int LW = 4;
  localparam int LINE_BYTES = 4 * LW;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic [31:0] cpu_addr;
  logic        flush;
  logic        cpu_resp_valid;
  logic [31:0] cpu_rdata;
  logic        cpu_resp_err;

  axi_read_if axi_if ();

  icache #(.LINE_NUM(LN), .LINE_WORDS(LW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_addr       (cpu_addr),
    .flush          (flush),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_rdata      (cpu_rdata),
    .cpu_resp_err   (cpu_resp_err),
    .axi_if         (axi_if)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- memory + reference model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  bit          model_valid [LN];
  int unsigned model_tag   [LN];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / LINE_BYTES) % LN);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a / (LINE_BYTES * LN);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return model_valid[idx_of(a)] && (model_tag[idx_of(a)] == tag_of(a));
  endfunction

  task automatic model_fill(input logic [31:0] a, input bit err);
    model_valid[idx_of(a)] = !err;
    model_tag[idx_of(a)]   = tag_of(a);
  endtask

  task automatic model_flush();
    for (int i = 0; i < LN; i++) model_valid[i] = 1'b0;
  endtask

  logic [31:0] exp_q[$];

  // ---------------- AXI slave model ----------------
  int          ar_count = 0;
  logic [31:0] last_araddr = '0;
  logic [7:0]  last_arlen = '0;
  bit          inject_err = 1'b0;

  initial begin
    bit          busy, f_ar, f_r, in_rst;
    logic [31:0] b_addr, s_araddr;
    logic [7:0]  b_len, s_arlen;
    int          beat;
    busy = 0; beat = 0; b_addr = '0; b_len = '0;
    axi_if.arready = 1'b0;
    axi_if.rvalid  = 1'b0;
    axi_if.rlast   = 1'b0;
    axi_if.rdata   = '0;
    axi_if.rresp   = AXI_RESP_OKAY;
    forever begin
      @(negedge clk);
      f_ar     = axi_if.arvalid && axi_if.arready;
      f_r      = axi_if.rvalid && axi_if.rready;
      in_rst   = !rst_n;
      s_araddr = axi_if.araddr;
      s_arlen  = axi_if.arlen;
      if (busy && f_r && !in_rst) begin
        n_checks++;
        if (s_araddr !== b_addr || s_arlen !== b_len) begin
          n_fail++;
          $display("FAIL ar_stable: got araddr=%h arlen=%0d want araddr=%h arlen=%0d",
                   s_araddr, s_arlen, b_addr, b_len);
        end
      end
      @(posedge clk);
      #2;
      if (in_rst) begin
        busy = 0;
        axi_if.arready = 1'b0;
        axi_if.rvalid  = 1'b0;
        axi_if.rlast   = 1'b0;
      end else begin
        if (f_ar) begin
          busy = 1; b_addr = s_araddr; b_len = s_arlen; beat = 0;
          ar_count++; last_araddr = s_araddr; last_arlen = s_arlen;
        end
        if (f_r && busy) begin
          beat++;
          if (beat > int'(b_len)) busy = 0;
        end
        axi_if.arready = !busy && ($urandom_range(0, 2) != 0);
        if (busy) begin
          axi_if.rvalid = ($urandom_range(0, 3) != 0);
          axi_if.rdata  = mem_word(b_addr + 32'(4 * beat));
          axi_if.rlast  = (beat == int'(b_len));
          axi_if.rresp  = (inject_err && beat == 2) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end else begin
          axi_if.rvalid = 1'b0;
          axi_if.rlast  = 1'b0;
        end
      end
    end
  end

  // cpu_resp_valid must never be high on two consecutive cycles.
  initial begin
    bit prev;
    prev = 0;
    forever begin
      @(negedge clk);
      if (prev) begin
        n_checks++;
        if (cpu_resp_valid === 1'b1) begin
          n_fail++;
          $display("FAIL resp_pulse: got resp_valid=1 twice in a row want single pulse");
        end
      end
      prev = (cpu_resp_valid === 1'b1);
    end
  end

  // ---------------- driver ----------------
  // mode 0: plain fetch; 1: flush pulse during refill; 2: reset during refill.
  task automatic drive_fetch(input logic [31:0] addr, input int mode,
                             output logic [31:0] data, output logic err,
                             output int lat, output int ars, output bit ok,
                             output bit pulsed, output logic [2:0] rst_obs);
    int start_ar;
    int cyc;
    bit saw_r;
    start_ar = ar_count;
    saw_r = 0; pulsed = 0; ok = 0; data = '0; err = 1'b0; lat = 0; rst_obs = '1;
    @(posedge clk); #1;
    cpu_req_valid = 1'b1;
    cpu_addr      = addr;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (cpu_req_ready !== 1'b1 && cyc < 50);
    if (cpu_req_ready !== 1'b1) begin
      cpu_req_valid = 1'b0;
      ars = ar_count - start_ar;
      return;
    end
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    cpu_addr      = $urandom;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cpu_resp_valid === 1'b1) begin
        data = cpu_rdata; err = cpu_resp_err; lat = cyc; ok = 1;
        break;
      end
      if (axi_if.rready === 1'b1) saw_r = 1;
      if (cyc >= 300) break;
      @(posedge clk); #1;
      flush = 1'b0;
      if (mode == 1 && saw_r && !pulsed) begin
        flush = 1'b1; pulsed = 1;
      end
      if (mode == 2 && saw_r) begin
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_obs = {axi_if.arvalid, axi_if.rready, cpu_resp_valid};
        @(posedge clk); #1;
        rst_n = 1'b1;
        ok = 1;
        break;
      end
    end
    flush = 1'b0;
    ars = ar_count - start_ar;
  endtask

  // ---------------- tests ----------------
  logic [31:0] d;
  logic        e;
  int          lat, ars;
  bit          ok, pulsed;
  logic [2:0]  robs;

  task automatic test_reset();
    rst_n = 1'b0; cpu_req_valid = 1'b0; cpu_addr = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_flush();
    @(negedge clk);
    n_checks++;
    if ({axi_if.arvalid, axi_if.rready, cpu_resp_valid, cpu_resp_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got arvalid,rready,resp_valid,resp_err=%b want 0000",
               {axi_if.arvalid, axi_if.rready, cpu_resp_valid, cpu_resp_err});
    end
    n_checks++;
    if (cpu_rdata !== 32'h0 || axi_if.araddr !== 32'h0 || axi_if.arlen !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_data: got rdata=%h araddr=%h arlen=%h want zeros",
               cpu_rdata, axi_if.araddr, axi_if.arlen);
    end
    n_checks++;
    if (cpu_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", cpu_req_ready);
    end
  endtask

  task automatic test_cold_miss();
    drive_fetch(32'h10, 0, d, e, lat, ars, ok, pulsed, robs);
    model_fill(32'h10, 0);
    n_checks++;
    if (!ok || ars != 1 || last_araddr !== 32'h10 || last_arlen !== 8'(LW - 1)) begin
      n_fail++;
      $display("FAIL cold_ar: got ok=%0d ars=%0d araddr=%h arlen=%0d want 1 1 00000010 %0d",
               ok, ars, last_araddr, last_arlen, LW - 1);
    end
    n_checks++;
    if (d !== mem_word(32'h10) || e !== 1'b0) begin
      n_fail++;
      $display("FAIL cold_data: got %h err=%b want %h err=0", d, e, mem_word(32'h10));
    end
  endtask

  task automatic test_hit();
    drive_fetch(32'h14, 0, d, e, lat, ars, ok, pulsed, robs);
    n_checks++;
    if (!ok || ars != 0 || lat != 2 || d !== mem_word(32'h14)) begin
      n_fail++;
      $display("FAIL hit_14: got ok=%0d ars=%0d lat=%0d data=%h want 1 0 2 %h",
               ok, ars, lat, d, mem_word(32'h14));
    end
    drive_fetch(32'h1B, 0, d, e, lat, ars, ok, pulsed, robs);
    n_checks++;
    if (!ok || ars != 0 || d !== mem_word(32'h18)) begin
      n_fail++;
      $display("FAIL hit_lowbits: got ok=%0d ars=%0d data=%h want 1 0 %h",
               ok, ars, d, mem_word(32'h18));
    end
  endtask

  task automatic test_conflict();
    drive_fetch(32'h110, 0, d, e, lat, ars, ok, pulsed, robs);
    model_fill(32'h110, 0);
    n_checks++;
    if (!ok || ars != 1 || last_araddr !== 32'h110 || d !== mem_word(32'h110)) begin
      n_fail++;
      $display("FAIL conflict_110: got ok=%0d ars=%0d araddr=%h data=%h want 1 1 00000110 %h",
               ok, ars, last_araddr, d, mem_word(32'h110));
    end
    drive_fetch(32'h010, 0, d, e, lat, ars, ok, pulsed, robs);
    model_fill(32'h010, 0);
    n_checks++;
    if (!ok || ars != 1 || last_araddr !== 32'h010 || d !== mem_word(32'h010)) begin
      n_fail++;
      $display("FAIL conflict_010: got ok=%0d ars=%0d araddr=%h data=%h want 1 1 00000010 %h",
               ok, ars, last_araddr, d, mem_word(32'h010));
    end
  endtask

  task automatic test_flush_refill();
    drive_fetch(32'h208, 1, d, e, lat, ars, ok, pulsed, robs);
    model_fill(32'h208, 0);
    if (pulsed) model_flush();
    n_checks++;
    if (!ok || !pulsed || ars != 1 || d !== mem_word(32'h208) || e !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_refill_resp: got ok=%0d pulsed=%0d ars=%0d data=%h want 1 1 1 %h",
               ok, pulsed, ars, d, mem_word(32'h208));
    end
    drive_fetch(32'h200, 0, d, e, lat, ars, ok, pulsed, robs);
    model_fill(32'h200, 0);
    n_checks++;
    if (!ok || ars != 1 || d !== mem_word(32'h200)) begin
      n_fail++;
      $display("FAIL flush_refill_remiss: got ok=%0d ars=%0d data=%h want 1 1 %h",
               ok, ars, d, mem_word(32'h200));
    end
    drive_fetch(32'h010, 0, d, e, lat, ars, ok, pulsed, robs);
    model_fill(32'h010, 0);
    n_checks++;
    if (!ok || ars != 1) begin
      n_fail++;
      $display("FAIL flush_refill_other: got ok=%0d ars=%0d want 1 1", ok, ars);
    end
  endtask

  task automatic test_flush_idle();
    @(posedge clk); #1;
    flush = 1'b1; cpu_req_valid = 1'b1; cpu_addr = 32'h14;
    @(negedge clk);
    n_checks++;
    if (cpu_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_ready: got %b want 0", cpu_req_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; cpu_req_valid = 1'b0;
    model_flush();
    drive_fetch(32'h14, 0, d, e, lat, ars, ok, pulsed, robs);
    model_fill(32'h14, 0);
    n_checks++;
    if (!ok || ars != 1 || d !== mem_word(32'h14)) begin
      n_fail++;
      $display("FAIL flush_idle_remiss: got ok=%0d ars=%0d data=%h want 1 1 %h",
               ok, ars, d, mem_word(32'h14));
    end
  endtask

  task automatic test_slverr();
    inject_err = 1'b1;
    drive_fetch(32'h300, 0, d, e, lat, ars, ok, pulsed, robs);
    inject_err = 1'b0;
    model_fill(32'h300, 1);
    n_checks++;
    if (!ok || ars != 1 || e !== 1'b1) begin
      n_fail++;
      $display("FAIL slverr_flag: got ok=%0d ars=%0d err=%b want 1 1 1", ok, ars, e);
    end
    drive_fetch(32'h304, 0, d, e, lat, ars, ok, pulsed, robs);
    model_fill(32'h304, 0);
    n_checks++;
    if (!ok || ars != 1 || e !== 1'b0 || d !== mem_word(32'h304)) begin
      n_fail++;
      $display("FAIL slverr_remiss: got ok=%0d ars=%0d err=%b data=%h want 1 1 0 %h",
               ok, ars, e, d, mem_word(32'h304));
    end
    drive_fetch(32'h308, 0, d, e, lat, ars, ok, pulsed, robs);
    n_checks++;
    if (!ok || ars != 0 || d !== mem_word(32'h308)) begin
      n_fail++;
      $display("FAIL slverr_refilled_hit: got ok=%0d ars=%0d data=%h want 1 0 %h",
               ok, ars, d, mem_word(32'h308));
    end
  endtask

  task automatic test_reset_mid();
    drive_fetch(32'h500, 0, d, e, lat, ars, ok, pulsed, robs);
    model_fill(32'h500, 0);
    drive_fetch(32'h600, 2, d, e, lat, ars, ok, pulsed, robs);
    model_flush();
    n_checks++;
    if (!ok || robs !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got ok=%0d arvalid,rready,resp_valid=%b want 1 000",
               ok, robs);
    end
    drive_fetch(32'h504, 0, d, e, lat, ars, ok, pulsed, robs);
    model_fill(32'h504, 0);
    n_checks++;
    if (!ok || ars != 1 || last_araddr !== 32'h500 || d !== mem_word(32'h504)) begin
      n_fail++;
      $display("FAIL reset_mid_remiss: got ok=%0d ars=%0d araddr=%h data=%h want 1 1 00000500 %h",
               ok, ars, last_araddr, d, mem_word(32'h504));
    end
  endtask

  task automatic test_back_to_back();
    int n_resp;
    int n_bad;
    int start_ar;
    drive_fetch(32'h14, 0, d, e, lat, ars, ok, pulsed, robs);
    model_fill(32'h14, 0);
    start_ar = ar_count;
    n_resp = 0; n_bad = 0;
    @(posedge clk); #1;
    cpu_req_valid = 1'b1; cpu_addr = 32'h1C;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cpu_resp_valid === 1'b1) begin
        n_resp++;
        if (cpu_rdata !== mem_word(32'h1C)) n_bad++;
      end
    end
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_resp != 4 || n_bad != 0 || ar_count != start_ar) begin
      n_fail++;
      $display("FAIL back_to_back: got resp=%0d bad=%0d ars=%0d want 4 0 0",
               n_resp, n_bad, ar_count - start_ar);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] exp_d;
    bit          exp_hit;
    int          mode;
    for (int i = 0; i < 150; i++) begin
      a = 32'($urandom_range(0, 255) * 4 + $urandom_range(0, 3));
      exp_hit = model_hit(a);
      mode = (!exp_hit && $urandom_range(0, 7) == 0) ? 1 : 0;
      exp_q.push_back(mem_word(a));
      drive_fetch(a, mode, d, e, lat, ars, ok, pulsed, robs);
      if (!exp_hit) model_fill(a, 0);
      if (pulsed) model_flush();
      exp_d = exp_q.pop_front();
      n_checks++;
      if (!ok || d !== exp_d || e !== 1'b0 || ars != (exp_hit ? 0 : 1)) begin
        n_fail++;
        $display("FAIL random_%0d addr=%h: got ok=%0d data=%h err=%b ars=%0d want 1 %h 0 %0d",
                 i, a, ok, d, e, ars, exp_d, exp_hit ? 0 : 1);
      end
      if (exp_hit) begin
        n_checks++;
        if (lat != 2) begin
          n_fail++;
          $display("FAIL random_hit_lat_%0d: got %0d want 2", i, lat);
        end
      end
      if ($urandom_range(0, 15) == 0) begin
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_flush();
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; cpu_req_valid = 1'b0; cpu_addr = '0; flush = 1'b0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush_refill();
    test_flush_idle();
    test_slverr();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
